// File: rtl/pipe_mux_tree.sv
// Binary 2^SEL_BITS:1 mux tree. Each level can optionally be registered, and valid and the
// full select travel with the data through every level.
module pipe_mux_tree #(
  parameter int unsigned         DATA_WIDTH = 8,
  parameter int unsigned         SEL_BITS   = 2,
  parameter logic [SEL_BITS-1:0] STAGE_MASK = {SEL_BITS{1'b1}}
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  clr,
  input  logic                                  in_valid,
  input  logic [SEL_BITS-1:0]                   sel,
  input  logic [(1 << SEL_BITS)*DATA_WIDTH-1:0] data_in,
  output logic                                  out_valid,
  output logic [SEL_BITS-1:0]                   out_sel,
  output logic [DATA_WIDTH-1:0]                 data_out
);

  localparam int unsigned N = 1 << SEL_BITS;

  for (genvar i = 0; i < SEL_BITS; i++) begin : gen_lvl
    localparam int unsigned NIn  = N >> i;
    localparam int unsigned NOut = NIn / 2;

    logic [NIn*DATA_WIDTH-1:0]  w_din;
    logic                       w_vin;
    logic [SEL_BITS-1:0]        w_sin;
    logic [NOut*DATA_WIDTH-1:0] w_mux;
    logic [NOut*DATA_WIDTH-1:0] w_dout;
    logic                       w_vout;
    logic [SEL_BITS-1:0]        w_sout;

    if (i == 0) begin : gen_src
      assign w_din = data_in;
      assign w_vin = in_valid;
      assign w_sin = sel;
    end else begin : gen_chain
      assign w_din = gen_lvl[i-1].w_dout;
      assign w_vin = gen_lvl[i-1].w_vout;
      assign w_sin = gen_lvl[i-1].w_sout;
    end

    // Node j of this level picks node 2j or 2j+1 of the previous one using sel[i].
    always_comb begin
      w_mux = '0;
      for (int j = 0; j < int'(NOut); j++) begin
        w_mux[j*DATA_WIDTH +: DATA_WIDTH] = w_sin[i] ? w_din[(2*j+1)*DATA_WIDTH +: DATA_WIDTH]
                                                     : w_din[(2*j)*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    if (STAGE_MASK[i]) begin : gen_reg
      logic [NOut*DATA_WIDTH-1:0] r_data;
      logic                       r_valid;
      logic [SEL_BITS-1:0]        r_sel;

      // clr only drops valid; data and sel copies keep their last values.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data  <= '0;
          r_valid <= 1'b0;
          r_sel   <= '0;
        end else if (clr) begin
          r_valid <= 1'b0;
        end else if (en) begin
          r_data  <= w_mux;
          r_valid <= w_vin;
          r_sel   <= w_sin;
        end
      end

      assign w_dout = r_data;
      assign w_vout = r_valid;
      assign w_sout = r_sel;
    end else begin : gen_comb
      assign w_dout = w_mux;
      assign w_vout = w_vin;
      assign w_sout = w_sin;
    end
  end

  assign data_out  = gen_lvl[SEL_BITS-1].w_dout;
  assign out_valid = gen_lvl[SEL_BITS-1].w_vout;
  assign out_sel   = gen_lvl[SEL_BITS-1].w_sout;

endmodule
